// File: rtl/timer_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_slave_pkg
// Purpose  : Register offsets and CTRL/STATUS bit positions for timer_slave.
// Revision : 1.0 - initial release
// ============================================================================
package timer_slave_pkg;

    typedef enum logic [2:0] {
        OFF_COUNT    = 3'd0,
        OFF_COMPARE  = 3'd1,
        OFF_CTRL     = 3'd2,
        OFF_STATUS   = 3'd3,
        OFF_PRESCALE = 3'd4
    } reg_off_e;

    localparam int CTRL_ENABLE     = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_W          = 3;
    localparam int STATUS_PENDING  = 0;

endpackage
`default_nettype wire

// File: rtl/timer_slave_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : timer_slave_prescaler
// Purpose  : Divides clk into count ticks; pcnt runs 0..prescale_i when enabled.
// Revision : 1.0 - initial release
// ============================================================================
module timer_slave_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic                  clear_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    assign tick_o = enable_i && (pcnt_q == prescale_i);

    always_comb begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
        if (clear_i || !enable_i || tick_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : timer_slave
// Purpose  : SRAM-style memory-mapped timer: prescaled counter, compare with
//            optional auto-reload, sticky pending flag and level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module timer_slave
    import timer_slave_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            timer_en,
    input  logic [3:0]      timer_wen,
    input  logic [XLEN-1:0] timer_addr,
    input  logic [XLEN-1:0] timer_wdata,
    output logic [XLEN-1:0] timer_rdata,
    output logic            irq
);

    localparam int LANES = XLEN / 8;

    logic [XLEN-1:0]       count_q,    count_d;
    logic [XLEN-1:0]       compare_q,  compare_d;
    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic                  pending_q,  pending_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [XLEN-1:0]       rdata_q,    rdata_d;

    reg_off_e              w_off;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tick;
    logic                  w_match;
    logic [XLEN-1:0]       w_count_inc;
    logic [XLEN-1:0]       w_lane_mask;
    logic                  w_unused_addr;

    assign w_off         = reg_off_e'(timer_addr[4:2]);
    assign w_wr          = timer_en && (timer_wen != 4'b0000);
    assign w_rd          = timer_en && (timer_wen == 4'b0000);
    assign w_unused_addr = ^{timer_addr[XLEN-1:5], timer_addr[1:0]};

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_lane_mask[8*i +: 8] = {8{timer_wen[i]}};
        end
    endgenerate

    timer_slave_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (ctrl_q[CTRL_ENABLE]),
        .prescale_i (prescale_q),
        .clear_i    (w_wr && (w_off == OFF_PRESCALE)),
        .tick_o     (w_tick)
    );

    assign w_count_inc = count_q + XLEN'(1);
    // A CPU write to COUNT suppresses both the increment and the match check.
    assign w_match = w_tick && !(w_wr && (w_off == OFF_COUNT))
                     && (w_count_inc == compare_q);

    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pending_d  = pending_q;

        if (w_wr && (w_off == OFF_COUNT)) begin
            count_d = (count_q & ~w_lane_mask) | (timer_wdata & w_lane_mask);
        end else if (w_tick) begin
            count_d = (w_match && ctrl_q[CTRL_AUTORELOAD]) ? '0 : w_count_inc;
        end

        if (w_wr && (w_off == OFF_COMPARE)) begin
            compare_d = (compare_q & ~w_lane_mask) | (timer_wdata & w_lane_mask);
        end

        if (w_wr && (w_off == OFF_CTRL) && timer_wen[0]) begin
            ctrl_d = timer_wdata[CTRL_W-1:0];
        end

        if (w_wr && (w_off == OFF_PRESCALE)) begin
            prescale_d = (prescale_q & ~w_lane_mask[PRESCALE_W-1:0])
                       | (timer_wdata[PRESCALE_W-1:0] & w_lane_mask[PRESCALE_W-1:0]);
        end

        // A new match outranks a simultaneous write-1-to-clear.
        if (w_match) begin
            pending_d = 1'b1;
        end else if (w_wr && (w_off == OFF_STATUS) && timer_wen[0]
                     && timer_wdata[STATUS_PENDING]) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (w_rd) begin
            case (w_off)
                OFF_COUNT:    rdata_d = count_q;
                OFF_COMPARE:  rdata_d = compare_q;
                OFF_CTRL:     rdata_d = XLEN'(ctrl_q);
                OFF_STATUS:   rdata_d = XLEN'(pending_q);
                OFF_PRESCALE: rdata_d = XLEN'(prescale_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            compare_q  <= '0;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            prescale_q <= '0;
            rdata_q    <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            prescale_q <= prescale_d;
            rdata_q    <= rdata_d;
        end
    end

    assign timer_rdata = rdata_q;
    assign irq         = pending_q && ctrl_q[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: tb/tb_timer_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_slave
// Purpose  : Randomised and directed scoreboard bench for timer_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        timer_en;
    logic [3:0]  timer_wen;
    logic [31:0] timer_addr;
    logic [31:0] timer_wdata;
    logic [31:0] timer_rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Reference state of the peripheral as seen by software.
    logic [31:0] m_count, m_compare;
    logic [2:0]  m_ctrl;
    logic        m_pend, m_irq;
    logic [15:0] m_presc;
    int          m_pcnt;

    timer_slave #(.XLEN(32), .PRESCALE_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .timer_en    (timer_en),
        .timer_wen   (timer_wen),
        .timer_addr  (timer_addr),
        .timer_wdata (timer_wdata),
        .timer_rdata (timer_rdata),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wen);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return m_count;
            1: return m_compare;
            2: return {29'd0, m_ctrl};
            3: return {31'd0, m_pend};
            4: return {16'd0, m_presc};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_count = 0; m_compare = 0; m_ctrl = 0; m_pend = 0; m_irq = 0;
        m_presc = 0; m_pcnt = 0;
    endtask

    // Advance the reference by one clock edge given the request on the bus.
    task automatic m_step(input logic en, input logic [3:0] wen, input int off,
                          input logic [31:0] wd);
        bit          wr    = en && (wen != 0);
        bit          tick  = m_ctrl[0] && (m_pcnt == int'(m_presc));
        bit          match = 0;
        logic [31:0] nc    = m_count;
        logic [31:0] npre;
        if (wr && off == 0) nc = merge(m_count, wd, wen);
        else if (tick) begin
            nc = m_count + 1;
            if (nc == m_compare) begin
                match = 1;
                if (m_ctrl[1]) nc = 0;
            end
        end
        if (wr && off == 4 || !m_ctrl[0] || tick) m_pcnt = 0;
        else m_pcnt = m_pcnt + 1;
        if (match) m_pend = 1;
        else if (wr && off == 3 && wen[0] && wd[0]) m_pend = 0;
        if (wr && off == 1) m_compare = merge(m_compare, wd, wen);
        if (wr && off == 2 && wen[0]) m_ctrl = wd[2:0];
        if (wr && off == 4) begin
            npre = merge({16'd0, m_presc}, wd, wen);
            m_presc = npre[15:0];
        end
        m_count = nc;
        m_irq   = m_pend && m_ctrl[2];
    endtask

    task automatic bus(input logic en, input logic [3:0] wen, input int off,
                       input logic [31:0] wd, input bit use_c = 0,
                       input logic [31:0] cval = 0);
        logic [31:0] a = $urandom;
        @(negedge clk);
        a[4:2]      = off[2:0];
        timer_en    = en;
        timer_wen   = wen;
        timer_addr  = a;
        timer_wdata = wd;
        if (en && wen == 0) exp_q.push_back(use_c ? cval : m_read(off));
        m_step(en, wen, off, wd);
    endtask

    task automatic wr(input int off, input logic [31:0] wd);
        bus(1'b1, 4'hF, off, wd);
    endtask

    task automatic rd(input int off, input bit use_c = 0, input logic [31:0] cval = 0);
        bus(1'b1, 4'h0, off, 32'h0, use_c, cval);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 4'h0, 0, $urandom);
    endtask

    // Monitor: read data appears one edge after the request is sampled.
    initial begin
        logic        rd_seen;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            rd_seen = reset && timer_en && (timer_wen == 4'h0);
            #1;
            if (rd_seen) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rdata: unexpected read response %h, none expected", timer_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (timer_rdata !== e) begin
                        n_err++;
                        $display("FAIL rdata @%0t: got %h expected %h", $time, timer_rdata, e);
                    end
                end
            end
            n_vec++;
            if (irq !== m_irq) begin
                n_err++;
                $display("FAIL irq @%0t: got %b expected %b", $time, irq, m_irq);
            end
        end
    end

    initial begin
        int off;
        logic [31:0] wd;
        reset = 1'b0; timer_en = 0; timer_wen = 0; timer_addr = 0; timer_wdata = 0;
        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state: every offset reads zero.
        for (int i = 0; i < 8; i++) rd(i, 1, 32'h0);

        // Partial byte-lane write.
        wr(1, 32'h1234_5678);
        bus(1'b1, 4'b0010, 1, 32'h0000_AB00);
        rd(1, 1, 32'h1234_AB78);

        // Basic match, no reload.
        wr(2, 32'h0); wr(4, 32'h0); wr(1, 32'd5); wr(0, 32'h0);
        wr(2, 32'b101);
        idle(7);
        rd(0);
        wr(3, 32'h1);
        idle(2);

        // Prescaled auto-reload.
        wr(2, 32'h0); wr(0, 32'h0); wr(4, 32'd3); wr(1, 32'd2);
        wr(2, 32'b111);
        for (int i = 0; i < 24; i++) rd(i % 2 == 0 ? 0 : 3);
        wr(3, 32'h1);
        idle(4);

        // COUNT write in a tick cycle wins.
        wr(4, 32'h0); wr(2, 32'b001);
        wr(0, 32'd100);
        rd(0, 1, 32'd100);

        // W1C coinciding with a match: pending stays set.
        wr(2, 32'h0); wr(3, 32'h1); wr(1, 32'd11); wr(0, 32'd10);
        wr(2, 32'b101);
        wr(3, 32'h1);
        rd(3, 1, 32'h1);

        // Wrap past 0xFFFFFFFF onto COMPARE=0.
        wr(2, 32'h0); wr(3, 32'h1); wr(0, 32'hFFFF_FFFE); wr(1, 32'h0); wr(4, 32'h0);
        wr(2, 32'b101);
        idle(2);
        rd(3, 1, 32'h1);
        rd(0);

        // Randomised traffic biased toward small values so matches occur.
        for (int i = 0; i < 800; i++) begin
            off = $urandom_range(0, 7);
            wd  = $urandom;
            if (off <= 1 || off == 4) wd = (($urandom_range(0, 3) == 0) ? wd : $urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0:       idle(1);
                1:       rd(off);
                2:       wr(off, wd);
                default: bus(1'b1, 4'($urandom_range(1, 15)), off, wd);
            endcase
        end

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        wr(2, 32'b101); wr(1, 32'd3); wr(0, 32'd0);
        idle(5);
        rd(1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        timer_en = 0; timer_wen = 0;
        m_reset();
        #1;
        n_vec++;
        if (timer_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 00000000", timer_rdata);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) rd(i, 1, 32'h0);
        idle(3);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d read responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
